hex_display_mux: RTL and testbench

Parametrised multi-digit, time-multiplexed 7-segment hex display driver for the board's common-anode displays. It captures a packed hex value into a shadow register on a load strobe and scans one digit per slot using a clock prescaler. It adds leading-zero suppression, per-digit blinking, global blanking and a frame-done pulse on top of single-digit hex decoding.

---
 rtl/hex_display_mux.sv | 131 +++++++++++++
 tb/tb_hex_display_mux.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hex_display_mux.sv
// Time-multiplexed common-anode hex display driver.
// One digit per prescaler slot, with zero suppression, blinking and blanking.
module hex_display_mux #(
  parameter int DIGITS       = 4,
  parameter int CLK_DIV      = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  input  logic                  print,
  input  logic                  lz_suppress,
  input  logic [DIGITS-1:0]     blink_mask,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(CLK_DIV - 1);
  localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_FRAMES - 1);

  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic [PW-1:0]       presc_q, presc_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [FW-1:0]       frm_q, frm_d;
  logic                phase_q, phase_d;
  logic [6:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                fd_q, fd_d;

  logic                tc;
  logic                wrap;
  logic                blank;
  logic [3:0]          nib;
  logic [DIGITS-1:0]   zero_above;

  // Active-low segment pattern (g..a) for one hex nibble.
  function automatic logic [6:0] hex7(input logic [3:0] h);
    logic [6:0] s;
    unique case (h)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
    endcase
    return s;
  endfunction

  // zero_above[k]: nibbles k..DIGITS-1 of the shadow are all zero.
  always_comb begin
    zero_above = '0;
    for (int k = 0; k < DIGITS; k++) begin
      zero_above[k] = ((shadow_q >> (4 * k)) == '0);
    end
  end

  // Scan timing, blink phase, shadow capture and output decode.
  always_comb begin
    tc       = (presc_q == PRE_LAST);
    wrap     = tc && (idx_q == IDX_LAST);
    presc_d  = tc ? '0 : presc_q + PW'(1);
    idx_d    = idx_q;
    frm_d    = frm_q;
    phase_d  = phase_q;
    shadow_d = load ? value : shadow_q;
    fd_d     = wrap;
    if (tc) begin
      idx_d = wrap ? '0 : idx_q + IW'(1);
    end
    if (wrap) begin
      if (frm_q == FRM_LAST) begin
        frm_d   = '0;
        phase_d = ~phase_q;
      end else begin
        frm_d = frm_q + FW'(1);
      end
    end
    nib   = shadow_q[{idx_q, 2'b00} +: 4];
    blank = !print
          | (blink_mask[idx_q] & phase_q)
          | (lz_suppress & (idx_q != '0) & zero_above[idx_q]);
    seg_d = blank ? 7'h7F : hex7(nib);
    an_d  = ~(DIGITS'(1) << idx_q);
  end

  // State and registered outputs; reset blanks the display at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= '0;
      presc_q  <= '0;
      idx_q    <= '0;
      frm_q    <= '0;
      phase_q  <= 1'b0;
      seg_q    <= 7'h7F;
      an_q     <= '1;
      fd_q     <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      frm_q    <= frm_d;
      phase_q  <= phase_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
      fd_q     <= fd_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_hex_display_mux.sv
// Bench for hex_display_mux: time-indexed reference model feeding a
// scoreboard queue, plus fixed display codes for the documented scenarios.
module tb_hex_display_mux;

  localparam int D  = 4;
  localparam int CD = 4;
  localparam int BF = 2;

  localparam logic [6:0] DEC [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = '0;
  logic        load = 1'b0;
  logic        print = 1'b0;
  logic        lz = 1'b0;
  logic [3:0]  bm = '0;
  logic [6:0]  seg, seg1;
  logic [3:0]  an, an1;
  logic        fd, fd1;

  always #5 clk = ~clk;

  hex_display_mux #(.DIGITS(D), .CLK_DIV(CD), .BLINK_FRAMES(BF)) u_dut (
    .clk(clk), .rst(rst), .value(value), .load(load), .print(print),
    .lz_suppress(lz), .blink_mask(bm),
    .seg(seg), .an(an), .frame_done(fd)
  );

  hex_display_mux #(.DIGITS(D), .CLK_DIV(1), .BLINK_FRAMES(BF)) u_div1 (
    .clk(clk), .rst(rst), .value(value), .load(load), .print(print),
    .lz_suppress(lz), .blink_mask(bm),
    .seg(seg1), .an(an1), .frame_done(fd1)
  );

  typedef struct packed {
    logic [6:0] seg;
    logic [3:0] an;
    logic       fd;
    logic [3:0] an1;
    logic       fd1;
  } exp_t;

  exp_t        sbq[$];
  exp_t        e;
  int          vecs = 0;
  int          errs = 0;
  int          n = 0;
  logic [15:0] sh_m = '0;

  // Code expected for the digit selected by a one-hot-low anode vector.
  function automatic logic [6:0] code_of(input logic [15:0] v,
                                         input logic [3:0] a);
    logic [6:0] s;
    s = 7'h7F;
    case (a)
      4'b1110: s = DEC[v[3:0]];
      4'b1101: s = DEC[v[7:4]];
      4'b1011: s = DEC[v[11:8]];
      4'b0111: s = DEC[v[15:12]];
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // Predict outputs after the coming edge from the edge count since
  // reset release, push them, then advance to the next falling edge.
  task automatic step();
    exp_t x;
    int   d, d1;
    logic ph, blank;
    n++;
    d     = ((n - 1) / CD) % D;
    ph    = ((((n - 1) / (CD * D * BF)) % 2) == 1);
    blank = !print || (bm[d] && ph)
          || (lz && d != 0 && ((sh_m >> (4 * d)) == 16'h0));
    x.seg = blank ? 7'h7F : DEC[sh_m[4*d +: 4]];
    x.an  = ~(4'b0001 << d);
    x.fd  = ((n % (CD * D)) == 0);
    d1    = (n - 1) % D;
    x.an1 = ~(4'b0001 << d1);
    x.fd1 = ((n % D) == 0);
    sbq.push_back(x);
    if (load) sh_m = value;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    load = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst  = 1'b0;
    n    = 0;
    sh_m = '0;
    sbq.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    vecs++;
    if (seg !== 7'h7F) begin
      errs++;
      $display("FAIL reset_seg got %h want 7f", seg);
    end
    if (an !== 4'hF) begin
      errs++;
      $display("FAIL reset_an got %b want 1111", an);
    end
    if (fd !== 1'b0 || fd1 !== 1'b0) begin
      errs++;
      $display("FAIL reset_fd got %b/%b want 0/0", fd, fd1);
    end
  endtask

  task automatic test_scan();
    int pulses;
    do_reset();
    print  = 1'b1;
    value  = 16'h1234;
    load   = 1'b1;
    pulses = 0;
    for (int i = 0; i < 33; i++) begin
      step();
      load = 1'b0;
      e = sbq.pop_front();
      vecs++;
      if (seg !== e.seg) begin
        errs++;
        $display("FAIL scan_seg n=%0d got %h want %h", n, seg, e.seg);
      end
      if (an !== e.an) begin
        errs++;
        $display("FAIL scan_an n=%0d got %b want %b", n, an, e.an);
      end
      if (fd !== e.fd) begin
        errs++;
        $display("FAIL scan_fd n=%0d got %b want %b", n, fd, e.fd);
      end
      if (n >= 2 && seg !== code_of(16'h1234, an)) begin
        errs++;
        $display("FAIL scan_code n=%0d got %h want %h",
                 n, seg, code_of(16'h1234, an));
      end
      if (fd === 1'b1) pulses++;
    end
    if (pulses != 2) begin
      errs++;
      $display("FAIL scan_fd_count got %0d want 2", pulses);
    end
  endtask

  task automatic test_lz();
    logic [6:0] want;
    do_reset();
    print = 1'b1;
    lz    = 1'b1;
    value = 16'h0050;
    load  = 1'b1;
    for (int i = 0; i < 54; i++) begin
      if (i == 18) begin
        value = 16'h0000;
        load  = 1'b1;
      end
      if (i == 38) lz = 1'b0;
      step();
      load = 1'b0;
      e = sbq.pop_front();
      vecs++;
      if (seg !== e.seg || an !== e.an || fd !== e.fd) begin
        errs++;
        $display("FAIL lz_model n=%0d got %h/%b/%b want %h/%b/%b",
                 n, seg, an, fd, e.seg, e.an, e.fd);
      end
      want = 7'h40;
      if (i >= 2 && i < 18) begin
        case (an)
          4'b1101: want = 7'h12;
          4'b1011: want = 7'h7F;
          4'b0111: want = 7'h7F;
          default: want = 7'h40;
        endcase
      end else if (i >= 20 && i < 38) begin
        want = (an == 4'b1110) ? 7'h40 : 7'h7F;
      end
      if (i >= 2 && i != 18 && i != 19 && seg !== want) begin
        errs++;
        $display("FAIL lz_code n=%0d an=%b got %h want %h",
                 n, an, seg, want);
      end
    end
  endtask

  task automatic test_blink();
    logic [6:0] want;
    do_reset();
    print = 1'b1;
    bm    = 4'b0001;
    value = 16'hABCD;
    load  = 1'b1;
    for (int i = 0; i < 80; i++) begin
      step();
      load = 1'b0;
      e = sbq.pop_front();
      vecs++;
      if (seg !== e.seg || an !== e.an || fd !== e.fd) begin
        errs++;
        $display("FAIL blink_model n=%0d got %h/%b/%b want %h/%b/%b",
                 n, seg, an, fd, e.seg, e.an, e.fd);
      end
      case (an)
        4'b1101: want = 7'h46;
        4'b1011: want = 7'h03;
        4'b0111: want = 7'h08;
        default: want = (n > 32 && n <= 64) ? 7'h7F : 7'h21;
      endcase
      if (n >= 2 && seg !== want) begin
        errs++;
        $display("FAIL blink_code n=%0d an=%b got %h want %h",
                 n, an, seg, want);
      end
    end
    bm = 4'b0000;
  endtask

  task automatic test_print();
    do_reset();
    print = 1'b0;
    value = 16'h1234;
    load  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      load = 1'b0;
      e = sbq.pop_front();
      vecs++;
      if (seg !== 7'h7F || an !== e.an || seg !== e.seg) begin
        errs++;
        $display("FAIL print_off n=%0d got %h/%b want 7f/%b",
                 n, seg, an, e.an);
      end
    end
    print = 1'b1;
    value = 16'h5678;
    while (((n + 1) % CD) != 0 || n < 36) begin
      step();
      e = sbq.pop_front();
      vecs++;
      if (seg !== e.seg || seg !== code_of(16'h1234, an)) begin
        errs++;
        $display("FAIL print_noload n=%0d got %h want %h",
                 n, seg, code_of(16'h1234, an));
      end
    end
    load = 1'b1;
    step();
    load = 1'b0;
    e = sbq.pop_front();
    vecs++;
    if (seg !== e.seg || seg !== code_of(16'h1234, an)) begin
      errs++;
      $display("FAIL print_load_edge1 n=%0d got %h want %h",
               n, seg, code_of(16'h1234, an));
    end
    step();
    e = sbq.pop_front();
    vecs++;
    if (seg !== e.seg || seg !== code_of(16'h5678, an)) begin
      errs++;
      $display("FAIL print_load_edge2 n=%0d got %h want %h",
               n, seg, code_of(16'h5678, an));
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    print = 1'b1;
    value = 16'h9999;
    load  = 1'b1;
    while (n < 9) begin
      step();
      load = 1'b0;
      e = sbq.pop_front();
    end
    vecs++;
    if (an !== 4'b1011 || seg !== 7'h10) begin
      errs++;
      $display("FAIL arst_pre got %h/%b want 10/1011", seg, an);
    end
    #2;
    rst = 1'b1;
    #1;
    vecs++;
    if (seg !== 7'h7F || an !== 4'hF || fd !== 1'b0) begin
      errs++;
      $display("FAIL arst_now got %h/%b/%b want 7f/1111/0", seg, an, fd);
    end
    do_reset();
    for (int i = 0; i < 16; i++) begin
      step();
      e = sbq.pop_front();
      vecs++;
      if (seg !== e.seg || an !== e.an || fd !== e.fd) begin
        errs++;
        $display("FAIL arst_after n=%0d got %h/%b/%b want %h/%b/%b",
                 n, seg, an, fd, e.seg, e.an, e.fd);
      end
      if (seg !== 7'h40) begin
        errs++;
        $display("FAIL arst_shadow n=%0d got %h want 40", n, seg);
      end
      if (i == 0 && an !== 4'b1110) begin
        errs++;
        $display("FAIL arst_restart got %b want 1110", an);
      end
    end
  endtask

  task automatic test_clkdiv1();
    int pulses;
    do_reset();
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      e = sbq.pop_front();
      vecs++;
      if (an1 !== e.an1) begin
        errs++;
        $display("FAIL div1_an n=%0d got %b want %b", n, an1, e.an1);
      end
      if (fd1 !== e.fd1) begin
        errs++;
        $display("FAIL div1_fd n=%0d got %b want %b", n, fd1, e.fd1);
      end
      if (fd1 === 1'b1) pulses++;
    end
    if (pulses != 3) begin
      errs++;
      $display("FAIL div1_fd_count got %0d want 3", pulses);
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_lz();
    test_blink();
    test_print();
    test_async_reset();
    test_clkdiv1();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
